// File: rtl/snes_pkg.sv
// Shared types and defaults for the SNES/NES serial pad poller.
package snes_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_CLK_LO,
        ST_CLK_HI,
        ST_DONE
    } state_t;

    localparam int DEF_POLL_DIV  = 1666667;
    localparam int DEF_LATCH_CYC = 1200;
    localparam int DEF_HALF_CYC  = 600;
    localparam int DEF_NUM_PADS  = 2;
    localparam int DEF_NUM_BITS  = 16;

    // Bit k of pad p lands here in the flat buttons word.
    function automatic int unsigned bit_pos(input int unsigned p, input int unsigned k,
                                            input int unsigned nbits);
        return p * nbits + k;
    endfunction

endpackage

// File: rtl/snes_sync.sv
// Parametrised-width two-flop synchroniser for asynchronous pad inputs.
module snes_sync #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/snes_pad_reader.sv
// Serial pad poller: drives latch/clock, shifts all pads in parallel, flags changes.
// Define SNES_DEBOUNCE_EN to accept a pad word only after two identical frames.
module snes_pad_reader
    import snes_pkg::*;
#(
    parameter int POLL_DIV  = DEF_POLL_DIV,
    parameter int LATCH_CYC = DEF_LATCH_CYC,
    parameter int HALF_CYC  = DEF_HALF_CYC,
    parameter int NUM_PADS  = DEF_NUM_PADS,
    parameter int NUM_BITS  = DEF_NUM_BITS
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_enable,
    input  logic [NUM_PADS-1:0]          i_pad_data,
    output logic                         o_data_latch,
    output logic                         o_data_clock,
    output logic [NUM_PADS*NUM_BITS-1:0] o_buttons,
    output logic                         o_valid,
    output logic [NUM_PADS-1:0]          o_changed,
    output logic                         o_irq,
    input  logic                         i_irq_ack
);

    localparam int MAXC = (LATCH_CYC > HALF_CYC) ? LATCH_CYC : HALF_CYC;
    localparam int PCW  = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int KW   = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

    localparam logic [PCW-1:0] POLL_LAST  = PCW'(POLL_DIV - 1);
    localparam logic [CW-1:0]  LATCH_LAST = CW'(LATCH_CYC - 1);
    localparam logic [CW-1:0]  HALF_LAST  = CW'(HALF_CYC - 1);
    localparam logic [KW-1:0]  BIT_LAST   = KW'(NUM_BITS - 1);

    state_t                            r_state;
    logic [PCW-1:0]                    r_poll_cnt;
    logic [CW-1:0]                     r_cnt;
    logic [KW-1:0]                     r_bit;
    logic                              r_latch;
    logic                              r_dclk;
    logic                              r_valid;
    logic                              r_irq;
    logic [NUM_PADS-1:0]               r_changed;
    logic [NUM_PADS-1:0][NUM_BITS-1:0] r_shift;
    logic [NUM_PADS-1:0][NUM_BITS-1:0] r_buttons;
`ifdef SNES_DEBOUNCE_EN
    logic [NUM_PADS-1:0][NUM_BITS-1:0] r_prev;
`endif

    logic                              w_tick;
    logic [NUM_PADS-1:0]               w_sync;
    logic [NUM_PADS-1:0]               w_accept;
    logic [NUM_PADS-1:0]               w_set;
    logic [NUM_PADS-1:0]               w_changed_nxt;
    logic [NUM_PADS-1:0][NUM_BITS-1:0] w_shift_nxt;
    logic [NUM_PADS-1:0][NUM_BITS-1:0] w_btn_nxt;

    // Pads idle high (nothing pressed), so the synchroniser resets to ones.
    snes_sync #(
        .WIDTH   (NUM_PADS),
        .RST_VAL ({NUM_PADS{1'b1}})
    ) u_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_pad_data),
        .o_q   (w_sync)
    );

    assign w_tick = (r_poll_cnt == POLL_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)       r_poll_cnt <= '0;
        else if (w_tick) r_poll_cnt <= '0;
        else             r_poll_cnt <= r_poll_cnt + 1'b1;
    end

    // Bits shift in from the top, so bit 0 (first out of the pad) ends at index 0.
    for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
        assign w_shift_nxt[p] = {~w_sync[p], r_shift[p][NUM_BITS-1:1]};
`ifdef SNES_DEBOUNCE_EN
        assign w_accept[p] = (r_shift[p] == r_prev[p]);
`else
        assign w_accept[p] = 1'b1;
`endif
        assign w_set[p]     = w_accept[p] && (r_shift[p] != r_buttons[p]);
        assign w_btn_nxt[p] = w_accept[p] ? r_shift[p] : r_buttons[p];
        for (genvar k = 0; k < NUM_BITS; k++) begin : g_bit
            assign o_buttons[bit_pos(p, k, NUM_BITS)] = r_buttons[p][k];
        end
    end

    // A fresh set in DONE survives a simultaneous ack.
    assign w_changed_nxt = (i_irq_ack ? '0 : r_changed)
                         | ((r_state == ST_DONE) ? w_set : '0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_latch   <= 1'b0;
            r_dclk    <= 1'b1;
            r_valid   <= 1'b0;
            r_irq     <= 1'b0;
            r_changed <= '0;
            r_shift   <= '0;
            r_buttons <= '0;
`ifdef SNES_DEBOUNCE_EN
            r_prev    <= '0;
`endif
        end else begin
            r_valid   <= 1'b0;
            r_changed <= w_changed_nxt;
            r_irq     <= |w_changed_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (w_tick && i_enable) begin
                        r_state <= ST_LATCH;
                        r_latch <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                ST_LATCH: begin
                    if (r_cnt == LATCH_LAST) begin
                        r_state <= ST_CLK_LO;
                        r_latch <= 1'b0;
                        r_dclk  <= 1'b0;
                        r_cnt   <= '0;
                        r_bit   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_CLK_LO: begin
                    if (r_cnt == HALF_LAST) begin
                        r_shift <= w_shift_nxt;
                        r_state <= ST_CLK_HI;
                        r_dclk  <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_CLK_HI: begin
                    if (r_cnt == HALF_LAST) begin
                        r_cnt <= '0;
                        if (r_bit == BIT_LAST) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_bit   <= r_bit + 1'b1;
                            r_state <= ST_CLK_LO;
                            r_dclk  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state   <= ST_IDLE;
                    r_valid   <= 1'b1;
                    r_buttons <= w_btn_nxt;
`ifdef SNES_DEBOUNCE_EN
                    r_prev    <= r_shift;
`endif
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_data_latch = r_latch;
    assign o_data_clock = r_dclk;
    assign o_valid      = r_valid;
    assign o_changed    = r_changed;
    assign o_irq        = r_irq;

endmodule

// File: tb/tb_snes_pad_reader.sv
// Directed/randomised bench for snes_pad_reader with behavioural pad and frame model.
module tb_snes_pad_reader;

    localparam int PD = 200;
    localparam int LC = 6;
    localparam int HC = 4;
    localparam int NP = 2;
    localparam int NB = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;
    logic irq_ack = 1'b0;
    logic [NP-1:0] pad_data;
    logic data_latch, data_clock, valid, irq;
    logic [NP*NB-1:0] buttons;
    logic [NP-1:0] changed;

    logic [NP-1:0][NB-1:0] pad_word;
    logic [NP-1:0][NB-1:0] exp_btn = '0;
    logic [NP-1:0][NB-1:0] m_prev = '0;
    logic [NP-1:0]         exp_chg = '0;
    int pad_idx = 0;
    int cyc = 0;
    int total = 0;
    int bad = 0;

    snes_pad_reader #(
        .POLL_DIV (PD), .LATCH_CYC (LC), .HALF_CYC (HC), .NUM_PADS (NP), .NUM_BITS (NB)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_enable     (enable),
        .i_pad_data   (pad_data),
        .o_data_latch (data_latch),
        .o_data_clock (data_clock),
        .o_buttons    (buttons),
        .o_valid      (valid),
        .o_changed    (changed),
        .o_irq        (irq),
        .i_irq_ack    (irq_ack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pad: latch reloads, each rising clock presents the next bit.
    always @(posedge data_latch or posedge data_clock) begin
        if (data_latch === 1'b1) pad_idx = 0;
        else                     pad_idx = pad_idx + 1;
    end

    always_comb begin
        pad_data = '0;
        for (int p = 0; p < NP; p++)
            pad_data[p] = (pad_idx < NB) ? pad_word[p][pad_idx[3:0]] : 1'b0;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Frame reference: pressed = ~raw; change flags are sticky until ack.
    task automatic model_frame(input logic ack);
        logic [NP-1:0] set;
        logic [NB-1:0] nw;
        logic acc;
        set = '0;
        for (int p = 0; p < NP; p++) begin
            nw = ~pad_word[p];
`ifdef SNES_DEBOUNCE_EN
            acc = (nw == m_prev[p]);
            m_prev[p] = nw;
`else
            acc = 1'b1;
`endif
            if (acc && nw != exp_btn[p]) begin
                exp_btn[p] = nw;
                set[p] = 1'b1;
            end
        end
        exp_chg = (ack ? '0 : exp_chg) | set;
    endtask

    task automatic wait_latch(input int limit, output int n);
        n = 0;
        while (data_latch !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("latch_seen", data_latch, 1'b1);
    endtask

    task automatic wait_valid(output int t);
        int n;
        n = 0;
        while (valid !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        t = cyc;
        chk("valid_seen", valid, 1'b1);
    endtask

    task automatic check_outputs(input string tag, input logic ack);
        model_frame(ack);
        chk({tag, "_buttons"}, buttons, exp_btn);
        chk({tag, "_changed"}, changed, exp_chg);
        chk({tag, "_irq"}, irq, |exp_chg);
        @(negedge clk);
        chk({tag, "_valid_once"}, valid, 1'b0);
    endtask

    task automatic wait_rises(input int target);
        int rises, n;
        logic prev;
        rises = 0;
        n = 0;
        prev = data_clock;
        while (rises < target && n < 1000) begin
            @(negedge clk);
            n++;
            if (!prev && data_clock) rises++;
            prev = data_clock;
        end
        chk("clock_rises", rises, target);
    endtask

    task automatic new_word(input int p);
        logic [NB-1:0] w;
        w = NB'($urandom);
        if (w == pad_word[p]) w = w ^ 16'h0001;
        pad_word[p] = w;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, m, t_lat0, t_v, lo, hi, seen;
        logic clk_dropped;
        logic [NB-1:0] base;

        pad_word[0] = 16'hFFFE;
        pad_word[1] = 16'h7FFF;
        repeat (3) @(negedge clk);
        chk("rst_latch", data_latch, 1'b0);
        chk("rst_clock", data_clock, 1'b1);
        chk("rst_buttons", buttons, '0);
        chk("rst_valid", valid, 1'b0);
        chk("rst_changed", changed, '0);
        chk("rst_irq", irq, 1'b0);

        // 1: first frame timing
        enable = 1'b1;
        rst = 1'b0;
        n = 0;
        clk_dropped = 1'b0;
        while (data_latch !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
            if (data_clock !== 1'b1) clk_dropped = 1'b1;
        end
        chk("first_latch_delay", n, PD);
        chk("clock_idle_high", clk_dropped, 1'b0);
        t_lat0 = cyc;
        m = 0;
        while (data_latch === 1'b1 && m < 50) begin
            m++;
            @(negedge clk);
        end
        chk("latch_width", m, LC);
        for (int i = 0; i < NB; i++) begin
            lo = 0;
            while (data_clock === 1'b0 && lo < 20) begin
                lo++;
                @(negedge clk);
            end
            chk("clk_low_len", lo, HC);
            if (i < NB - 1) begin
                hi = 0;
                while (data_clock === 1'b1 && hi < 20) begin
                    hi++;
                    @(negedge clk);
                end
                chk("clk_high_len", hi, HC);
            end
        end
        wait_valid(t_v);
        chk("frame_len", t_v - t_lat0, LC + 2 * NB * HC + 1);

        // 2: decoded first frame
        check_outputs("first", 1'b0);

        // 3: ack, then identical frame
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        exp_chg = '0;
        chk("ack_changed", changed, '0);
        chk("ack_irq", irq, 1'b0);
        wait_latch(400, n);
        wait_valid(t_v);
        check_outputs("same", 1'b0);

        // 4: pad0 change, then pad1 change with ack landing on DONE
        new_word(0);
        wait_latch(400, n);
        wait_valid(t_v);
        check_outputs("pad0chg", 1'b0);
        new_word(1);
        wait_latch(400, n);
        repeat (LC + 2 * NB * HC) @(negedge clk);
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        chk("ackset_valid", valid, 1'b1);
        check_outputs("ackset", 1'b1);

        // 5: enable dropped during CLK_HI of bit 5
        new_word(0);
        new_word(1);
        wait_latch(400, n);
        wait_rises(6);
        @(negedge clk);
        enable = 1'b0;
        wait_valid(t_v);
        check_outputs("en_drop", 1'b0);
        seen = 0;
        repeat (450) begin
            @(negedge clk);
            if (data_latch === 1'b1) seen++;
        end
        chk("no_latch_disabled", seen, 0);
        enable = 1'b1;
        wait_latch(250, n);
        chk("resume_phase", (cyc - t_lat0) % PD, 0);
        wait_valid(t_v);
        check_outputs("resume", 1'b0);

        // 6: reset during bit 9 aborts at once
        new_word(0);
        new_word(1);
        wait_latch(400, n);
        wait_rises(9);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_clock", data_clock, 1'b1);
        chk("arst_latch", data_latch, 1'b0);
        chk("arst_buttons", buttons, '0);
        chk("arst_changed", changed, '0);
        chk("arst_irq", irq, 1'b0);
        exp_btn = '0;
        exp_chg = '0;
        m_prev = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_latch(1000, n);
        chk("post_rst_latch_delay", n, PD);
        wait_valid(t_v);
        check_outputs("post_rst", 1'b0);

        // Single-frame glitch on pad0 bit 3 between stable frames
        base = NB'($urandom);
        pad_word[1] = NB'($urandom);
        for (int f = 0; f < 4; f++) begin
            pad_word[0] = (f == 2) ? (base ^ 16'h0008) : base;
            wait_latch(400, n);
            wait_valid(t_v);
            check_outputs("glitch", 1'b0);
        end

        // A few fully random frames
        for (int f = 0; f < 3; f++) begin
            pad_word[0] = NB'($urandom);
            pad_word[1] = NB'($urandom);
            if (f == 1) begin
                irq_ack = 1'b1;
                @(negedge clk);
                irq_ack = 1'b0;
                exp_chg = '0;
            end
            wait_latch(400, n);
            wait_valid(t_v);
            check_outputs("rand", 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
